// File: rtl/jk_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : jk_cmd_sequencer
// Description : Queues JK flip-flop commands (op + repeat count) in a small
//               FIFO and plays them back on registered J/K outputs. Each
//               command drives J/K for cmd_rpt+1 cycles. Back-to-back commands
//               follow each other with no idle cycle between them.
//
// Ports       : clk        - rising-edge clock
//               reset      - asynchronous, active-low reset
//               cmd_valid  - command offered
//               cmd_op     - 00 hold, 01 reset, 10 set, 11 toggle (J=op[1], K=op[0])
//               cmd_rpt    - op is held for cmd_rpt+1 cycles
//               cmd_ready  - FIFO has room (fifo_level < DEPTH)
//               J, K       - registered drive to the downstream JK flip-flop
//               busy       - a command is playing
//               q_pred     - predicted downstream Q (0 unless shadow enabled)
//               fifo_level - queued entries, excluding the playing command
//
// Macro       : JK_SEQ_SHADOW_EN - when defined, adds a shadow JK flip-flop
//               that tracks J/K and drives q_pred. When undefined, q_pred
//               is tied to 0.
//
// Revision    : 1.0 - initial release
// ============================================================================
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  input  logic [1:0]               cmd_op,
  input  logic [CNT_W-1:0]         cmd_rpt,
  output logic                     cmd_ready,
  output logic                     J,
  output logic                     K,
  output logic                     busy,
  output logic                     q_pred,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = 2 + CNT_W;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_PLAY = 1'b1;

  // FIFO storage: {op, rpt}; contents need no reset, only the pointers do
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             j_q, j_d;
  logic             k_q, k_d;
  logic             busy_q, busy_d;

  logic             push;
  logic             pop;
  logic             nonempty;
  logic [ENT_W-1:0] head;

  assign cmd_ready  = (level_q < LVL_W'(DEPTH));
  assign push       = cmd_valid & cmd_ready;
  assign nonempty   = (level_q != '0);
  assign head       = mem_q[rd_ptr_q];

  assign J          = j_q;
  assign K          = k_q;
  assign busy       = busy_q;
  assign fifo_level = level_q;

  // Playback FSM. A pop happens only when the FIFO was already non-empty
  // before this edge, so a command pushed now starts one edge later.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    j_d     = j_q;
    k_d     = k_q;
    busy_d  = busy_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (nonempty) begin
          pop     = 1'b1;
          j_d     = head[CNT_W+1];
          k_d     = head[CNT_W];
          cnt_d   = head[CNT_W-1:0];
          busy_d  = 1'b1;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (nonempty) begin
          // Chain straight into the next command without a bubble
          pop     = 1'b1;
          j_d     = head[CNT_W+1];
          k_d     = head[CNT_W];
          cnt_d   = head[CNT_W-1:0];
        end else begin
          j_d     = 1'b0;
          k_d     = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      j_q      <= 1'b0;
      k_q      <= 1'b0;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      j_q      <= j_d;
      k_q      <= k_d;
      busy_q   <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_op, cmd_rpt};
    end
  end

`ifdef JK_SEQ_SHADOW_EN
  // Shadow flip-flop sees the same registered J/K as the downstream device
  logic q_pred_q, q_pred_d;

  always_comb begin
    case ({j_q, k_q})
      2'b01:   q_pred_d = 1'b0;
      2'b10:   q_pred_d = 1'b1;
      2'b11:   q_pred_d = ~q_pred_q;
      default: q_pred_d = q_pred_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_pred_q <= 1'b0;
    end else begin
      q_pred_q <= q_pred_d;
    end
  end

  assign q_pred = q_pred_q;
`else
  assign q_pred = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jk_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_cmd_sequencer
// Description : Self-checking bench for jk_cmd_sequencer. The reference model
//               keeps a timeline of accepted commands: each command is given
//               a start edge (one edge after acceptance, or right when the
//               previous command ends) and expected outputs are read off that
//               timeline. Build with +define+JK_SEQ_SHADOW_EN to also check
//               the predicted Q; otherwise q_pred must stay 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   cmd_valid;
  logic [1:0]             cmd_op;
  logic [CNT_W-1:0]       cmd_rpt;
  logic                   cmd_ready;
  logic                   J, K, busy, q_pred;
  logic [$clog2(DEPTH):0] fifo_level;

  jk_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_rpt    (cmd_rpt),
    .cmd_ready  (cmd_ready),
    .J          (J),
    .K          (K),
    .busy       (busy),
    .q_pred     (q_pred),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model: command timeline ----------------
  typedef struct {
    logic [1:0] op;
    int         rpt;
    int         start;
  } cmd_t;

  cmd_t q_cmds[$];
  int   edge_n   = 0;
  int   last_end = 0;   // first edge at which the last scheduled command is no longer active
  logic exp_j = 1'b0, exp_k = 1'b0, exp_busy = 1'b0, exp_q = 1'b0;

  // Entries accepted but not yet started are the ones sitting in the FIFO
  function automatic int model_level();
    int n = 0;
    foreach (q_cmds[i]) if (q_cmds[i].start > edge_n) n++;
    return n;
  endfunction

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    if (j && k) return ~q;
    if (j)      return 1'b1;
    if (k)      return 1'b0;
    return q;
  endfunction

  task automatic model_clear();
    q_cmds.delete();
    last_end = 0;
    exp_j = 1'b0; exp_k = 1'b0; exp_busy = 1'b0; exp_q = 1'b0;
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "_J"},     J,          exp_j);
    check({pfx, "_K"},     K,          exp_k);
    check({pfx, "_busy"},  busy,       exp_busy);
    check({pfx, "_level"}, fifo_level, model_level());
`ifdef JK_SEQ_SHADOW_EN
    check({pfx, "_qpred"}, q_pred,     exp_q);
`else
    check({pfx, "_qpred"}, q_pred,     1'b0);
`endif
  endtask

  // One clock cycle: drive inputs, advance the model, compare outputs
  task automatic step(input logic v, input logic [1:0] op, input int rpt);
    int   lvl;
    int   s;
    cmd_t c;
    @(negedge clk);
    cmd_valid = v;
    cmd_op    = op;
    cmd_rpt   = CNT_W'(rpt);
    lvl = model_level();
    check("ready", cmd_ready, (lvl < DEPTH));
    @(posedge clk);
    edge_n++;
    if (v && lvl < DEPTH) begin
      s = (edge_n + 1 > last_end) ? edge_n + 1 : last_end;
      c.op = op; c.rpt = rpt; c.start = s;
      q_cmds.push_back(c);
      last_end = s + rpt + 1;
    end
    exp_q = jk_next(exp_q, exp_j, exp_k);
    while (q_cmds.size() > 0 && q_cmds[0].start + q_cmds[0].rpt + 1 <= edge_n)
      void'(q_cmds.pop_front());
    if (q_cmds.size() > 0 && q_cmds[0].start <= edge_n) begin
      exp_j = q_cmds[0].op[1]; exp_k = q_cmds[0].op[0]; exp_busy = 1'b1;
    end else begin
      exp_j = 1'b0; exp_k = 1'b0; exp_busy = 1'b0;
    end
    #1;
    check_outputs("cyc");
  endtask

  // Asynchronous reset pulse between clock edges (called just after a step)
  task automatic mid_reset();
    #1;
    reset = 1'b0;
    cmd_valid = 1'b0;
    #1;
    model_clear();
    check_outputs("rst");
    check("rst_ready", cmd_ready, 1'b1);
    #6;
    reset = 1'b1;
  endtask

  initial begin
    // Reset held low for 12 ns with a command offered
    reset     = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_rpt   = '0;
    #2;  check_outputs("por0"); check("por0_ready", cmd_ready, 1'b1);
    #5;  check_outputs("por1"); check("por1_ready", cmd_ready, 1'b1);
    #4;  check_outputs("por2"); check("por2_ready", cmd_ready, 1'b1);
    #1;
    cmd_valid = 1'b0;
    reset     = 1'b1;

    // Single set command into an idle block
    step(1'b1, 2'b10, 2);
    repeat (6) step(1'b0, 2'b00, 0);

    // Back-to-back chaining: set, reset x2, toggle x4
    step(1'b1, 2'b10, 0);
    step(1'b1, 2'b01, 1);
    step(1'b1, 2'b11, 3);
    repeat (10) step(1'b0, 2'b00, 0);

    // Fill the FIFO behind a long command; extra offers are dropped
    step(1'b1, 2'b11, 15);
    for (int i = 0; i < 8; i++) step(1'b1, 2'(i), i % 3);
    repeat (30) step(1'b0, 2'b00, 0);

    // Reset mid-play with two commands queued; nothing may play afterwards
    step(1'b1, 2'b11, 5);
    step(1'b1, 2'b01, 1);
    step(1'b1, 2'b10, 2);
    step(1'b0, 2'b00, 0);
    mid_reset();
    repeat (5) step(1'b0, 2'b00, 0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 2) != 0),
           2'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 2)));
      if (i % 150 == 149) mid_reset();
    end
    repeat (40) step(1'b0, 2'b00, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jk_cmd_sequencer.md
JK_CMD_SEQUENCER -- requirements
Module: jk_cmd_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4: command FIFO entries, a power of two, at least 2.
REQ-002 The block SHALL have parameter CNT_W, default 4: repeat-count width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports clk and reset.
REQ-004 Port clk: input, 1 bit, rising-edge clock.
REQ-005 Port reset: input, 1 bit, asynchronous, active-low reset.
REQ-006 Port cmd_valid: input, 1 bit, command offered.
REQ-007 Port cmd_op: input, 2 bits, JK operation: 00 hold, 01 reset, 10 set, 11 toggle.
REQ-008 Port cmd_rpt: input, CNT_W bits; the op is held for cmd_rpt+1 cycles.
REQ-009 Port cmd_ready: output, 1 bit, block can accept a command.
REQ-010 Port J: output, 1 bit, registered drive to the downstream JK flip-flop.
REQ-011 Port K: output, 1 bit, registered drive to the downstream JK flip-flop.
REQ-012 Port busy: output, 1 bit, high while a command is playing.
REQ-013 Port q_pred: output, 1 bit, predicted downstream Q.
REQ-014 Port fifo_level: output, $clog2(DEPTH)+1 bits, occupancy.

Function
REQ-015 A command SHALL be accepted on a rising clk edge where cmd_valid and cmd_ready are both 1, and written to the FIFO tail.
REQ-016 cmd_ready SHALL equal (fifo_level < DEPTH); cmd_valid while cmd_ready=0 SHALL be ignored and not stored.
REQ-017 The FSM SHALL have the states IDLE and PLAY.
REQ-018 IDLE: when the FIFO is non-empty at an edge, the block SHALL pop the head, load J/K from the op (J=op[1], K=op[0]), load the remaining count from rpt, set busy=1 and go to PLAY.
REQ-019 Latency: J/K SHALL change on the edge after the acceptance edge when the FIFO was empty and the block was IDLE.
REQ-020 PLAY: while the remaining count is nonzero, the block SHALL decrement it each edge and hold J/K.
REQ-021 PLAY, remaining count = 0, FIFO non-empty: the block SHALL pop the next command on the same edge with no bubble cycle.
REQ-022 PLAY, remaining count = 0, FIFO empty: the block SHALL set J=K=0 and busy=0 and go to IDLE.
REQ-023 Each command SHALL therefore drive J/K for exactly rpt+1 cycles.
REQ-024 Push and pop on the same edge SHALL leave fifo_level unchanged and both operations SHALL take effect.
REQ-025 A push when fifo_level=DEPTH-1 SHALL bring the level to DEPTH, and cmd_ready SHALL fall on that edge.
REQ-026 FIFO pointers SHALL wrap modulo DEPTH, and entries SHALL be retired in order.
REQ-027 fifo_level SHALL count the queued entries only; the currently playing command is not counted.

Reset
REQ-028 reset=0 SHALL immediately, independent of clk, set the state to IDLE and set J=0, K=0, busy=0, q_pred=0, fifo_level=0 and the FIFO pointers to 0, discarding queued and playing commands.
REQ-029 Reset asserted mid-PLAY SHALL abort the playing command; after release the first edge SHALL accept commands normally.
REQ-030 cmd_ready SHALL read 1 during and after reset.

Configuration
REQ-031 The macro JK_SEQ_SHADOW_EN SHALL control the shadow model of the downstream flip-flop.
REQ-032 With JK_SEQ_SHADOW_EN defined, q_pred SHALL update on every edge from its own value and the current J/K: 00 hold, 01 to 0, 10 to 1, 11 invert.
REQ-033 With JK_SEQ_SHADOW_EN defined, q_pred SHALL match the Q of a JK flip-flop on the same clk and reset that is fed J/K.
REQ-034 Without JK_SEQ_SHADOW_EN, q_pred SHALL be tied to 0 and no shadow logic SHALL exist.

Verification
REQ-035 The bench SHALL drive reset low for 12 ns with cmd_valid=1 -> J=K=0, busy=0, fifo_level=0, cmd_ready=1 throughout reset.
REQ-036 The bench SHALL push a single op=10, rpt=2 into an idle block -> J=1, K=0 for exactly 3 cycles starting the next edge, then J=K=0 and busy=0.
REQ-037 The bench SHALL push op=10 rpt=0, then 01 rpt=1, then 11 rpt=3 back-to-back -> J/K sequence 10, 01, 01, 11, 11, 11, 11 with no gaps, and (shadow on) q_pred 1, 0, 0, 1, 0, 1, 0.
REQ-038 The bench SHALL hold cmd_valid=1 with DEPTH=4 while a long command (rpt=15) plays -> 4 accepts, cmd_ready=0, the 5th command is dropped, and the level falls to 3 with ready=1 on the first pop.
REQ-039 The bench SHALL assert reset low for 7 ns mid-PLAY with 2 commands queued -> J=K=0 and fifo_level=0 asynchronously, and nothing plays after release.
REQ-040 The bench SHALL build and run the toggle test without JK_SEQ_SHADOW_EN -> q_pred stays constant 0 while J/K behave identically.
